outbuf_writer: RTL and testbench

Output-side memory writer for the CNN pipeline: accepts one convolution result per valid beat from the 3x3 window datapath, packs the three per-channel signed accumulators into an RGB888 word, and writes it sequentially into the output block RAM. It is the write-side counterpart of the input-buffer read path. It tracks frame position, signals completion and flags protocol errors.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/px_clip8.sv | 38 +++
 rtl/outbuf_writer.sv | 176 +++++++++++++++++
 tb/tb_outbuf_writer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN pipeline types: writer FSM states, output geometry helpers, RGB888 layout
//
// Contents:
//   state_t        writer FSM encoding (IDLE, RUN, FLUSH, DONE)
//   out_dim()      valid-convolution output size for a 3x3 window (input size - 2)
//   out_depth()    number of output pixels for a WIDTH x HEIGHT input frame
//   R_LSB/G_LSB/B_LSB, CH_W   RGB888 channel bit positions in the packed word

package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Packed RGB888: R in [23:16], G in [15:8], B in [7:0].
    localparam int CH_W  = 8;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    function automatic int out_dim(input int in_dim);
        return in_dim - 2;
    endfunction

    function automatic int out_depth(input int in_w, input int in_h);
        return (in_w - 2) * (in_h - 2);
    endfunction

endpackage

// File: rtl/px_clip8.sv
// rtl/px_clip8.sv - reduce one signed channel accumulator to an 8-bit pixel value
//
// Ports:
//   acc   in   ACC_W  signed channel accumulator
//   px    out  8      pixel channel value
//
// Build option OUTBUF_CLIP_EN:
//   defined   -> saturate to unsigned 0..255 (negative -> 0, >255 -> 255)
//   undefined -> plain truncation to the low 8 bits

module px_clip8 #(
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [7:0]       px
);

`ifdef OUTBUF_CLIP_EN
    // Any set bit between bit 8 and the sign bit means the positive value exceeds 255.
    logic over;
    assign over = |acc[ACC_W-2:8];

    always_comb begin
        px = acc[7:0];
        if (acc[ACC_W-1]) begin
            px = 8'h00;
        end else if (over) begin
            px = 8'hFF;
        end
    end
`else
    // Upper accumulator bits are intentionally dropped in truncation mode.
    logic unused_hi;
    assign unused_hi = ^acc[ACC_W-1:8];
    assign px        = acc[7:0];
`endif

endmodule

// File: rtl/outbuf_writer.sv
// rtl/outbuf_writer.sv - CNN output-side memory writer: packs per-channel results to RGB888 and writes them sequentially
//
// Ports:
//   iClk, iRst          clock, asynchronous active-low reset
//   iEn                 pipeline clock enable (paces acceptance of beats)
//   iStart              one-cycle pulse arming a new frame (aborts a running one)
//   iValid              result beat present, sampled only when iEn=1
//   iR, iG, iB          signed ACC_W channel accumulators
//   oCs, oWe            memory chip select / write enable, one cycle per accepted beat
//   oAddr, oData        memory address / packed {R,G,B} word
//   oBusy               frame in progress (RUN and FLUSH)
//   oDone               one-cycle pulse after the last write
//   oErr                sticky: beat accepted outside RUN; cleared by reset or iStart
//
// Build option OUTBUF_CLIP_EN selects saturating channel reduction inside px_clip8.

module outbuf_writer
    import cnn_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int ACC_W     = 20,
    parameter int ADDR_W    = 17,
    parameter int WIDTH     = 24,
    parameter int HEIGHT    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iEn,
    input  logic                     iStart,
    input  logic                     iValid,
    input  logic signed [ACC_W-1:0]  iR,
    input  logic signed [ACC_W-1:0]  iG,
    input  logic signed [ACC_W-1:0]  iB,
    output logic                     oCs,
    output logic                     oWe,
    output logic        [ADDR_W-1:0] oAddr,
    output logic        [DATA_W-1:0] oData,
    output logic                     oBusy,
    output logic                     oDone,
    output logic                     oErr
);

    localparam int OUT_W = out_dim(WIDTH);
    localparam int OUT_H = out_dim(HEIGHT);
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_0   = ADDR_W'(BASE_ADDR);

    state_t state, state_n;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_cnt;

    logic        accept;
    logic        last_px;
    logic        write_now;
    logic        clear_cnt;
    logic        clear_err;
    logic        err_beat;

    logic [7:0]        px_r, px_g, px_b;
    logic [DATA_W-1:0] packed_px;

    px_clip8 #(.ACC_W(ACC_W)) u_clip_r (.acc(iR), .px(px_r));
    px_clip8 #(.ACC_W(ACC_W)) u_clip_g (.acc(iG), .px(px_g));
    px_clip8 #(.ACC_W(ACC_W)) u_clip_b (.acc(iB), .px(px_b));

    always_comb begin
        packed_px                = '0;
        packed_px[R_LSB +: CH_W] = px_r;
        packed_px[G_LSB +: CH_W] = px_g;
        packed_px[B_LSB +: CH_W] = px_b;
    end

    assign accept  = iEn & iValid;
    assign last_px = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // iStart has priority over a coincident beat: it re-arms the frame and
    // that beat is neither written nor flagged.
    always_comb begin
        state_n   = state;
        write_now = 1'b0;
        clear_cnt = 1'b0;
        clear_err = 1'b0;
        err_beat  = 1'b0;
        unique case (state)
            IDLE: begin
                clear_cnt = 1'b1;
                if (iStart) begin
                    clear_err = 1'b1;
                    state_n   = RUN;
                end else if (accept) begin
                    err_beat = 1'b1;
                end
            end
            RUN: begin
                if (iStart) begin
                    clear_cnt = 1'b1;
                    clear_err = 1'b1;
                end else if (accept) begin
                    write_now = 1'b1;
                    if (last_px) begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                err_beat = accept;
                state_n  = DONE;
            end
            DONE: begin
                err_beat = accept;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oCs      <= 1'b0;
            oWe      <= 1'b0;
            oAddr    <= ADDR_0;
            oData    <= '0;
            oErr     <= 1'b0;
            col      <= '0;
            row      <= '0;
            addr_cnt <= ADDR_0;
        end else begin
            // Write strobes last exactly one cycle; address/data hold afterwards.
            oCs <= write_now;
            oWe <= write_now;
            if (write_now) begin
                oAddr <= addr_cnt;
                oData <= packed_px;
            end

            if (clear_cnt) begin
                col      <= '0;
                row      <= '0;
                addr_cnt <= ADDR_0;
            end else if (write_now) begin
                addr_cnt <= addr_cnt + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (clear_err) begin
                oErr <= 1'b0;
            end else if (err_beat) begin
                oErr <= 1'b1;
            end
        end
    end

    assign oBusy = (state == RUN) || (state == FLUSH);
    assign oDone = (state == DONE);

endmodule

// File: tb/tb_outbuf_writer.sv
// tb/tb_outbuf_writer.sv - self-checking bench for outbuf_writer (pack table, full frame, enable pacing, errors, abort, reset)

module tb_outbuf_writer;

    localparam int DATA_W = 24;
    localparam int ACC_W  = 20;
    localparam int ADDR_W = 17;
    localparam int NBEATS = 110;

    logic                     iClk = 1'b0;
    logic                     iRst;
    logic                     iEn;
    logic                     iStart;
    logic                     iValid;
    logic signed [ACC_W-1:0]  iR, iG, iB;
    logic                     oCs, oWe, oBusy, oDone, oErr;
    logic        [ADDR_W-1:0] oAddr;
    logic        [DATA_W-1:0] oData;

    int n_chk  = 0;
    int n_pass = 0;

    outbuf_writer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W),
        .WIDTH(24), .HEIGHT(7), .BASE_ADDR(0)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iValid(iValid),
        .iR(iR), .iG(iG), .iB(iB),
        .oCs(oCs), .oWe(oWe), .oAddr(oAddr), .oData(oData),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int          r;
        int          g;
        int          b;
        logic [23:0] exp_trunc;
        logic [23:0] exp_clip;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input bit en, input bit valid, input bit start, input int r, input int g, input int b);
        iEn    = en;
        iValid = valid;
        iStart = start;
        iR     = r[ACC_W-1:0];
        iG     = g[ACC_W-1:0];
        iB     = b[ACC_W-1:0];
    endtask

    function automatic logic [23:0] pick(input vec_t v);
`ifdef OUTBUF_CLIP_EN
        return v.exp_clip;
`else
        return v.exp_trunc;
`endif
    endfunction

    initial begin
        logic [23:0] e;
        int r, g, b;

        vecs[0] = '{r: 'h1FF,    g: 'h100, b: -1,       exp_trunc: 24'hFF00FF, exp_clip: 24'hFFFF00};
        vecs[1] = '{r: -5,       g: 300,   b: 128,      exp_trunc: 24'hFB2C80, exp_clip: 24'h00FF80};
        vecs[2] = '{r: 0,        g: 255,   b: 256,      exp_trunc: 24'h00FF00, exp_clip: 24'h00FFFF};
        vecs[3] = '{r: 12,       g: 34,    b: 56,       exp_trunc: 24'h0C2238, exp_clip: 24'h0C2238};
        vecs[4] = '{r: -256,     g: -129,  b: 'h7FFFF,  exp_trunc: 24'h007FFF, exp_clip: 24'h0000FF};
        vecs[5] = '{r: 'h80000,  g: 1,     b: 'h301,    exp_trunc: 24'h000101, exp_clip: 24'h0001FF};

        iRst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check("reset_cs",    32'(oCs),   32'h0);
        check("reset_we",    32'(oWe),   32'h0);
        check("reset_addr",  32'(oAddr), 32'h0);
        check("reset_data",  32'(oData), 32'h0);
        check("reset_busy",  32'(oBusy), 32'h0);
        check("reset_done",  32'(oDone), 32'h0);
        check("reset_err",   32'(oErr),  32'h0);
        repeat (2) step();
        iRst = 1'b1;
        step();

        // Full frame, back-to-back beats; first six use the pack table.
        drive(1, 0, 1, 0, 0, 0);
        step();
        check("start_busy", 32'(oBusy), 32'h1);
        check("start_we",   32'(oWe),   32'h0);
        for (int i = 0; i < NBEATS; i++) begin
            if (i < 6) begin
                r = vecs[i].r; g = vecs[i].g; b = vecs[i].b;
                e = pick(vecs[i]);
            end else begin
                r = i; g = i + 1; b = i + 2;
                e = {8'(i), 8'(i + 1), 8'(i + 2)};
            end
            drive(1, 1, 0, r, g, b);
            step();
            check($sformatf("frame_we[%0d]", i),   32'(oWe & oCs), 32'h1);
            check($sformatf("frame_addr[%0d]", i), 32'(oAddr),     32'(i));
            check($sformatf("frame_data[%0d]", i), 32'(oData),     32'(e));
            if (i == NBEATS - 1) begin
                check("flush_busy", 32'(oBusy), 32'h1);
                check("flush_done", 32'(oDone), 32'h0);
            end
        end
        drive(1, 0, 0, 0, 0, 0);
        step();
        check("done_pulse", 32'(oDone), 32'h1);
        check("done_we",    32'(oWe),   32'h0);
        check("done_busy",  32'(oBusy), 32'h0);
        step();
        check("done_once",  32'(oDone), 32'h0);
        check("frame_err",  32'(oErr),  32'h0);

        // Extra beat after completion: flagged, not written.
        drive(1, 1, 0, 1, 2, 3);
        step();
        check("extra_we",  32'(oWe),  32'h0);
        check("extra_cs",  32'(oCs),  32'h0);
        check("extra_err", 32'(oErr), 32'h1);
        drive(1, 0, 0, 0, 0, 0);
        step();
        check("err_sticky", 32'(oErr), 32'h1);
        drive(1, 0, 1, 0, 0, 0);
        step();
        check("start_clr_err", 32'(oErr),  32'h0);
        check("restart_busy",  32'(oBusy), 32'h1);

        // iEn 1:3 with iValid held high: writes only for enabled cycles.
        for (int k = 0; k < 12; k++) begin
            drive((k % 4) == 0, 1, 0, k + 3, k + 4, k + 5);
            step();
            check($sformatf("en_we[%0d]", k), 32'(oWe), 32'((k % 4) == 0));
            if ((k % 4) == 0) begin
                check($sformatf("en_addr[%0d]", k), 32'(oAddr), 32'(k / 4));
                check($sformatf("en_data[%0d]", k), 32'(oData), 32'({8'(k + 3), 8'(k + 4), 8'(k + 5)}));
            end
        end

        // Continue to 40 beats, then abort; the next beat restarts at BASE_ADDR.
        for (int j = 3; j < 40; j++) begin
            drive(1, 1, 0, j, j, j);
            step();
            check($sformatf("pre_abort_addr[%0d]", j), 32'(oAddr), 32'(j));
        end
        check("pre_abort_we", 32'(oWe), 32'h1);
        drive(1, 0, 1, 0, 0, 0);
        step();
        check("abort_we",   32'(oWe),   32'h0);
        check("abort_busy", 32'(oBusy), 32'h1);
        drive(1, 1, 0, 7, 8, 9);
        step();
        check("abort_next_we",   32'(oWe),   32'h1);
        check("abort_next_addr", 32'(oAddr), 32'h0);
        check("abort_next_data", 32'(oData), 32'h070809);

        // Asynchronous reset mid-frame drops the pending write immediately.
        drive(1, 1, 0, 1, 1, 1);
        step();
        check("pre_rst_we",   32'(oWe),   32'h1);
        check("pre_rst_addr", 32'(oAddr), 32'h1);
        #2;
        iRst = 1'b0;
        #1;
        check("rst_async_we",   32'(oWe),   32'h0);
        check("rst_async_cs",   32'(oCs),   32'h0);
        check("rst_async_addr", 32'(oAddr), 32'h0);
        check("rst_async_data", 32'(oData), 32'h0);
        check("rst_async_busy", 32'(oBusy), 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        iRst = 1'b1;
        step();
        check("post_rst_busy", 32'(oBusy), 32'h0);
        drive(1, 1, 0, 5, 5, 5);
        step();
        check("post_rst_idle_we",  32'(oWe),  32'h0);
        check("post_rst_idle_err", 32'(oErr), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
